// File: rtl/contador_vl_pkg.sv
// Shared types for the multimode up/down counter.
// Holds the counting-mode encoding and its width.
package contador_vl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    UP_WRAP   = 2'd0,
    DOWN_WRAP = 2'd1,
    BOUNCE    = 2'd2,
    UP_SAT    = 2'd3
  } mode_t;

endpackage

// File: rtl/contador_vl_next.sv
// Combinational next-state function of the counter.
// Ports: saida/dir (current state), mode, lim_min/lim_max (bounds)
//   -> saida_nx, dir_nx, tc_nx. Assumes saida is within bounds.
module contador_vl_next
  import contador_vl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] saida,
  input  logic             dir,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] lim_min,
  input  logic [WIDTH-1:0] lim_max,
  output logic [WIDTH-1:0] saida_nx,
  output logic             dir_nx,
  output logic             tc_nx
);

  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic             at_min;
  logic             at_max;
  logic             single;
  logic             going_down;

  // inc/dec are only selected when the bound check rules out overflow
  assign inc    = saida + 1'b1;
  assign dec    = saida - 1'b1;
  assign at_min = (saida == lim_min);
  assign at_max = (saida == lim_max);
  assign single = (lim_min == lim_max);

  // bounce: already sitting on the bound we head for -> turn around
  assign going_down = dir ? !at_min : at_max;

  always_comb begin
    saida_nx = saida;
    dir_nx   = dir;
    tc_nx    = 1'b0;
    unique case (mode)
      UP_WRAP: begin
        dir_nx = 1'b0;
        if (single) begin
          tc_nx = 1'b1;
        end else if (at_max) begin
          saida_nx = lim_min;
        end else begin
          saida_nx = inc;
          tc_nx    = (inc == lim_max);
        end
      end
      DOWN_WRAP: begin
        dir_nx = 1'b1;
        if (single) begin
          tc_nx = 1'b1;
        end else if (at_min) begin
          saida_nx = lim_max;
        end else begin
          saida_nx = dec;
          tc_nx    = (dec == lim_min);
        end
      end
      BOUNCE: begin
        if (single) begin
          tc_nx = 1'b1;
        end else if (going_down) begin
          saida_nx = dec;
          tc_nx    = (dec == lim_min);
          dir_nx   = !(dec == lim_min);
        end else begin
          saida_nx = inc;
          tc_nx    = (inc == lim_max);
          dir_nx   = (inc == lim_max);
        end
      end
      UP_SAT: begin
        dir_nx = 1'b0;
        if (single) begin
          tc_nx = 1'b1;
        end else if (!at_max) begin
          saida_nx = inc;
          tc_nx    = (inc == lim_max);
        end
      end
    endcase
  end

endmodule

// File: rtl/contador_vl_multimodo.sv
// Runtime-configurable multimode counter: registers, priority, clamp.
// Ports: clock, reset, en, load, load_val, mode, lim_min, lim_max
//   -> saida, dir, tc, cfg_err (all registered).
module contador_vl_multimodo
  import contador_vl_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] lim_min,
  input  logic [WIDTH-1:0] lim_max,
  output logic [WIDTH-1:0] saida,
  output logic             dir,
  output logic             tc,
  output logic             cfg_err
);

  logic [WIDTH-1:0] saida_nx;
  logic             dir_nx;
  logic             tc_nx;
  logic [WIDTH-1:0] clamped;
  logic             bad_cfg;
  logic             out_rng;

  assign bad_cfg = (lim_min > lim_max);
  assign out_rng = (saida < lim_min) || (saida > lim_max);

  assign clamped = (load_val < lim_min) ? lim_min :
                   (load_val > lim_max) ? lim_max : load_val;

  contador_vl_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .saida   (saida),
    .dir     (dir),
    .mode    (mode),
    .lim_min (lim_min),
    .lim_max (lim_max),
    .saida_nx(saida_nx),
    .dir_nx  (dir_nx),
    .tc_nx   (tc_nx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida   <= RST_VAL;
      dir     <= 1'b0;
      tc      <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bad_cfg;
      tc      <= 1'b0;
      if (bad_cfg) begin
        saida <= saida;
      end else if (load) begin
        saida <= clamped;
      end else if (en) begin
        if (out_rng) begin
          saida <= lim_min;
          dir   <= 1'b0;
        end else begin
          saida <= saida_nx;
          dir   <= dir_nx;
          tc    <= tc_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_contador_vl_multimodo.sv
// Directed self-checking bench for contador_vl_multimodo.
// WIDTH=4, RST_VAL=0; checks follow each rising edge by 1 time unit.
module tb_contador_vl_multimodo;
  import contador_vl_pkg::*;

  logic       clock;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  mode_t      mode;
  logic [3:0] lim_min;
  logic [3:0] lim_max;
  logic [3:0] saida;
  logic       dir;
  logic       tc;
  logic       cfg_err;

  int vectors = 0;
  int errs    = 0;

  contador_vl_multimodo #(
    .WIDTH  (4),
    .RST_VAL(4'd0)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .mode    (mode),
    .lim_min (lim_min),
    .lim_max (lim_max),
    .saida   (saida),
    .dir     (dir),
    .tc      (tc),
    .cfg_err (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [3:0] s,
                         input logic d, input logic t);
    chk({tag, ".saida"}, 32'(saida), 32'(s));
    chk({tag, ".dir"}, 32'(dir), 32'(d));
    chk({tag, ".tc"}, 32'(tc), 32'(t));
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    mode     = BOUNCE;
    lim_min  = 4'd0;
    lim_max  = 4'd15;
    #12;
    expect3("reset", 4'd0, 1'b0, 1'b0);
    chk("reset.cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;

    // 1: bounce over the full range
    step();
    en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      expect3("bounce_up", 4'(i), (i == 15), (i == 15));
    end
    for (int i = 14; i >= 0; i--) begin
      step();
      expect3("bounce_dn", 4'(i), (i != 0), (i == 0));
    end
    step();
    expect3("bounce_turn", 4'd1, 1'b0, 1'b0);

    // en=0 holds
    en = 1'b0;
    step();
    expect3("hold", 4'd1, 1'b0, 1'b0);
    en = 1'b1;

    // 2: up_wrap 3..6, recovery from 1 first
    mode    = UP_WRAP;
    lim_min = 4'd3;
    lim_max = 4'd6;
    step();
    expect3("recover", 4'd3, 1'b0, 1'b0);
    step(); expect3("upw4", 4'd4, 1'b0, 1'b0);
    step(); expect3("upw5", 4'd5, 1'b0, 1'b0);
    step(); expect3("upw6", 4'd6, 1'b0, 1'b1);
    step(); expect3("upw3", 4'd3, 1'b0, 1'b0);
    step(); expect3("upw4b", 4'd4, 1'b0, 1'b0);
    mode = DOWN_WRAP;
    step(); expect3("dnw3", 4'd3, 1'b1, 1'b1);
    step(); expect3("dnw6", 4'd6, 1'b1, 1'b0);
    step(); expect3("dnw5", 4'd5, 1'b1, 1'b0);
    step(); expect3("dnw4", 4'd4, 1'b1, 1'b0);
    step(); expect3("dnw3b", 4'd3, 1'b1, 1'b1);

    // 3: load with clamp
    mode     = UP_WRAP;
    lim_min  = 4'd2;
    lim_max  = 4'd7;
    load     = 1'b1;
    load_val = 4'd9;
    step(); expect3("load_hi", 4'd7, 1'b1, 1'b0);
    load_val = 4'd0;
    step(); expect3("load_lo", 4'd2, 1'b1, 1'b0);
    load = 1'b0;

    // 4: bad configuration freezes
    lim_min = 4'd8;
    lim_max = 4'd5;
    step();
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    expect3("cfg_frz", 4'd2, 1'b1, 1'b0);
    load = 1'b1;
    step();
    expect3("cfg_frz2", 4'd2, 1'b1, 1'b0);
    load    = 1'b0;
    lim_min = 4'd0;
    lim_max = 4'd15;
    step();
    chk("cfg_err_clr", 32'(cfg_err), 32'd0);
    expect3("cfg_resume", 4'd3, 1'b0, 1'b0);

    // 5: async reset mid-cycle at saida=9
    mode = DOWN_WRAP;
    step(); expect3("dn2", 4'd2, 1'b1, 1'b0);
    step(); expect3("dn1", 4'd1, 1'b1, 1'b0);
    step(); expect3("dn0", 4'd0, 1'b1, 1'b1);
    step(); expect3("dn15", 4'd15, 1'b1, 1'b0);
    for (int i = 14; i >= 9; i--) step();
    expect3("dn9", 4'd9, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    expect3("async_rst", 4'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;

    // 6: saturating up then shrink bound
    mode    = UP_SAT;
    lim_min = 4'd0;
    lim_max = 4'd3;
    step(); expect3("sat1", 4'd1, 1'b0, 1'b0);
    step(); expect3("sat2", 4'd2, 1'b0, 1'b0);
    step(); expect3("sat3", 4'd3, 1'b0, 1'b1);
    step(); expect3("sat3b", 4'd3, 1'b0, 1'b0);
    step(); expect3("sat3c", 4'd3, 1'b0, 1'b0);
    lim_max = 4'd2;
    step(); expect3("shrink", 4'd0, 1'b0, 1'b0);

    // single-value range
    mode    = UP_WRAP;
    lim_min = 4'd5;
    lim_max = 4'd5;
    step(); expect3("single_rec", 4'd5, 1'b0, 1'b0);
    step(); expect3("single_tc", 4'd5, 1'b0, 1'b1);
    mode = DOWN_WRAP;
    step(); expect3("single_dn", 4'd5, 1'b1, 1'b1);
    mode = BOUNCE;
    step(); expect3("single_bnc", 4'd5, 1'b1, 1'b1);

    // bounce from top bound with dir=0 turns around
    lim_min = 4'd0;
    lim_max = 4'd15;
    mode    = UP_SAT;
    load    = 1'b1;
    load_val = 4'd15;
    step(); expect3("ld15", 4'd15, 1'b1, 1'b0);
    load = 1'b0;
    step(); expect3("sat_top", 4'd15, 1'b0, 1'b0);
    mode = BOUNCE;
    step(); expect3("bnc_turn", 4'd14, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
